// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } apb_state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts APB wait states; expired flags the last allowed ACCESS cycle.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic Hclk,
  input  logic Hresetn,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_ok;
      assign unused_ok = ^{Hclk, Hresetn, clr, inc};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt;

      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge value of its neighbours.
      always_ff @(posedge Hclk) begin
        if (!Hresetn)  cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (inc)  cnt <= cnt + 1'b1;
      end

      assign expired = (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb3_fsm_controller.sv
// APB3 master FSM: one AHB transfer at a time, SETUP/ACCESS with wait-state
// timeout and a two-cycle AHB ERROR response.
module apb3_fsm_controller
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              valid,
  input  logic              Hwrite,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [NSLV-1:0]   tempselx,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready,
  input  logic              Pslverr,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Pwrite,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable,
  output logic              Hreadyout,
  output logic              Hresp,
  output logic [DATA_W-1:0] Hrdata
);

  apb_state_t      state, state_d;
  logic [NSLV-1:0] sel_q, sel_d;
  logic            accept;
  logic            timer_expired;

  assign accept = (state == ST_IDLE) && valid && Hreadyout;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .clr     (state == ST_SETUP),
    .inc     ((state == ST_ACCESS) && !Pready),
    .expired (timer_expired)
  );

  // NOTE: defaults first so no path through the case leaves a latch.
  always_comb begin
    state_d = state;
    sel_d   = sel_q;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          sel_d = tempselx;
          if (tempselx == '0) state_d = ST_ERR1;
          else if (Hwrite)    state_d = ST_WWAIT;
          else                state_d = ST_SETUP;
        end
      end
      ST_WWAIT:  state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (Pready)             state_d = Pslverr ? ST_ERR1 : ST_IDLE;
        else if (timer_expired) state_d = ST_ERR1;
      end
      ST_ERR1:   state_d = ST_ERR2;
      ST_ERR2:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each one is the Moore
  // decode of the state register without a combinational output path.
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Pwrite    <= 1'b0;
      Hrdata    <= '0;
      Pselx     <= '0;
      Penable   <= 1'b0;
      Hreadyout <= 1'b1;
      Hresp     <= HRESP_OKAY;
    end else begin
      state <= state_d;
      sel_q <= sel_d;
      if (accept) begin
        Paddr  <= Haddr;
        Pwrite <= Hwrite;
      end
      if (state == ST_WWAIT) Pwdata <= Hwdata;
      if (state == ST_ACCESS && Pready && !Pslverr && !Pwrite) Hrdata <= Prdata;

      Pselx     <= (state_d == ST_SETUP || state_d == ST_ACCESS) ? sel_d : '0;
      Penable   <= (state_d == ST_ACCESS);
      Hreadyout <= (state_d == ST_IDLE) || (state_d == ST_ERR2);
      Hresp     <= (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    end
  end

endmodule

// File: tb/tb_apb3_fsm_controller.sv
// Scoreboard bench: driver pushes expected per-transfer results, monitor
// pops and compares at each AHB completion.
module tb_apb3_fsm_controller;

  localparam int T = 4;

  logic        Hclk, Hresetn, valid, Hwrite, Pready, Pslverr;
  logic [31:0] Haddr, Hwdata, Prdata;
  logic [2:0]  tempselx;
  logic [31:0] Paddr, Pwdata, Hrdata;
  logic        Pwrite, Penable, Hreadyout, Hresp;
  logic [2:0]  Pselx;

  apb3_fsm_controller #(.ADDR_W(32), .DATA_W(32), .NSLV(3), .TIMEOUT(T)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid), .Hwrite(Hwrite),
    .Haddr(Haddr), .tempselx(tempselx), .Hwdata(Hwdata), .Prdata(Prdata),
    .Pready(Pready), .Pslverr(Pslverr), .Paddr(Paddr), .Pwdata(Pwdata),
    .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable), .Hreadyout(Hreadyout),
    .Hresp(Hresp), .Hrdata(Hrdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  sel;
    logic        write;
    logic [31:0] wdata;
    logic        resp;
    logic [31:0] rdata;
    int          pen;
    int          selc;
    int          errc;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        mon_en = 1'b0;
  logic [31:0] model_rdata = '0;
  int          cur_w = 0;
  logic        cur_err = 1'b0;
  logic [31:0] cur_rdata = '0;

  initial begin
    Hclk = 1'b0;
    forever #5 Hclk = ~Hclk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // APB slave: Pready rises after cur_w wait cycles of ACCESS.
  initial begin
    int acc_cnt = 0;
    Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
    forever begin
      @(negedge Hclk);
      if (Penable) begin
        Pready  = (acc_cnt == cur_w);
        Pslverr = Pready ? cur_err : 1'($urandom);
        Prdata  = Pready ? cur_rdata : $urandom;
        acc_cnt++;
      end else begin
        acc_cnt = 0;
        Pready  = 1'($urandom);
        Pslverr = 1'($urandom);
        Prdata  = $urandom;
      end
    end
  end

  // Reference: a transfer is an error if unmapped, slave error, or the slave
  // needs T or more wait cycles; ACCESS lasts min(w+1, T) cycles.
  task automatic issue(input logic [31:0] addr, input logic [2:0] sel, input logic write,
                       input logic [31:0] wdata, input int w, input logic err,
                       input logic [31:0] rdata);
    exp_t e;
    int   guard = 0;
    while (!(Hreadyout && !Hresp)) begin
      valid = 1'($urandom); Haddr = $urandom; tempselx = 3'($urandom); Hwrite = 1'($urandom);
      @(negedge Hclk);
      guard++;
      if (guard > 60) begin
        vectors++; miscompares++;
        $display("FAIL idle_wait: Hreadyout=%0b Hresp=%0b required 1/0", Hreadyout, Hresp);
        valid = 1'b0;
        return;
      end
    end
    e.addr = addr; e.sel = sel; e.write = write; e.wdata = wdata;
    if (sel == 3'b000) begin
      e.resp = 1'b1; e.pen = 0; e.selc = 0;
    end else begin
      e.resp = err || (w >= T);
      e.pen  = (w < T) ? w + 1 : T;
      e.selc = e.pen + 1;
      if (!e.resp && !write) model_rdata = rdata;
    end
    e.rdata = model_rdata;
    e.errc  = e.resp ? 1 : 0;
    exp_q.push_back(e);
    cur_w = w; cur_err = err; cur_rdata = rdata;
    valid = 1'b1; Haddr = addr; tempselx = sel; Hwrite = write; Hwdata = $urandom;
    @(negedge Hclk);
    valid = 1'b0; Haddr = $urandom; tempselx = 3'($urandom); Hwrite = 1'($urandom);
    Hwdata = wdata;
    @(negedge Hclk);
    Hwdata = $urandom;
  endtask

  // Monitor: per-cycle APB stability checks and per-transfer result checks.
  initial begin
    exp_t e;
    logic prev_rdy = 1'b1;
    int   pen_cyc = 0, sel_cyc = 0, err_cyc = 0;
    forever begin
      @(negedge Hclk);
      if (!mon_en) begin
        pen_cyc = 0; sel_cyc = 0; err_cyc = 0;
      end else begin
        if (Pselx != 3'b000) begin
          sel_cyc++;
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            check("paddr", 64'(Paddr), 64'(e.addr));
            check("pselx", 64'(Pselx), 64'(e.sel));
            check("pwrite", 64'(Pwrite), 64'(e.write));
            if (e.write) check("pwdata", 64'(Pwdata), 64'(e.wdata));
          end else begin
            check("pselx_no_txn", 64'(Pselx), 64'(0));
          end
        end
        if (Penable) pen_cyc++;
        if (Hresp && !Hreadyout) err_cyc++;
        if (Hreadyout && !prev_rdy) begin
          if (exp_q.size() == 0) begin
            check("spurious_done", 64'(exp_q.size()), 64'(1));
          end else begin
            e = exp_q.pop_front();
            check("hresp", 64'(Hresp), 64'(e.resp));
            check("hrdata", 64'(Hrdata), 64'(e.rdata));
            check("access_cycles", 64'(pen_cyc), 64'(e.pen));
            check("psel_cycles", 64'(sel_cyc), 64'(e.selc));
            check("err1_cycles", 64'(err_cyc), 64'(e.errc));
          end
          pen_cyc = 0; sel_cyc = 0; err_cyc = 0;
        end
      end
      prev_rdy = Hreadyout;
    end
  end

  initial begin
    int guard;
    Hresetn = 1'b0; valid = 1'b0; Hwrite = 1'b0; Haddr = '0; tempselx = '0; Hwdata = '0;
    repeat (3) @(negedge Hclk);
    check("rst_paddr", 64'(Paddr), 64'(0));
    check("rst_pwdata", 64'(Pwdata), 64'(0));
    check("rst_pwrite", 64'(Pwrite), 64'(0));
    check("rst_pselx", 64'(Pselx), 64'(0));
    check("rst_penable", 64'(Penable), 64'(0));
    check("rst_hreadyout", 64'(Hreadyout), 64'(1));
    check("rst_hresp", 64'(Hresp), 64'(0));
    check("rst_hrdata", 64'(Hrdata), 64'(0));
    Hresetn = 1'b1;
    @(negedge Hclk);
    mon_en = 1'b1;

    issue(32'h40, 3'b010, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_0001);
    issue(32'h80, 3'b001, 1'b1, 32'h1234_5678, 3, 1'b0, 32'h0);
    issue(32'h44, 3'b100, 1'b0, 32'h0, 0, 1'b1, 32'hDEAD_BEEF);
    issue(32'h48, 3'b010, 1'b0, 32'h0, T, 1'b0, 32'h1111_2222);
    issue(32'h4C, 3'b010, 1'b0, 32'h0, T - 1, 1'b0, 32'h3333_4444);
    issue(32'h50, 3'b000, 1'b0, 32'h0, 0, 1'b0, 32'h5555_6666);
    issue(32'h54, 3'b001, 1'b1, 32'hA5A5_5A5A, T + 1, 1'b0, 32'h0);

    // Reset in the middle of ACCESS of a long read.
    issue(32'h58, 3'b100, 1'b0, 32'h0, 40, 1'b0, 32'h7777_8888);
    mon_en = 1'b0;
    Hresetn = 1'b0;
    @(negedge Hclk);
    check("midrst_pselx", 64'(Pselx), 64'(0));
    check("midrst_penable", 64'(Penable), 64'(0));
    check("midrst_hreadyout", 64'(Hreadyout), 64'(1));
    check("midrst_hresp", 64'(Hresp), 64'(0));
    check("midrst_hrdata", 64'(Hrdata), 64'(0));
    Hresetn = 1'b1;
    exp_q.delete();
    model_rdata = '0;
    @(negedge Hclk);
    mon_en = 1'b1;
    issue(32'h5C, 3'b010, 1'b0, 32'h0, 1, 1'b0, 32'h9999_AAAA);

    for (int i = 0; i < 150; i++) begin
      logic [2:0] sel;
      sel = ($urandom_range(0, 5) == 0) ? 3'b000 : 3'(1 << $urandom_range(0, 2));
      issue($urandom, sel, 1'($urandom), $urandom, $urandom_range(0, T + 1),
            ($urandom_range(0, 3) == 0), $urandom);
    end

    valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge Hclk);
      guard++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
